z80_alu: RTL and testbench

- Z80 8-bit ALU with registered outputs, used in the cz80 CPU core datapath.
- Performs add/sub, logic, compare, rotate/shift, bit test/set/reset, DAA and RLD/RRD on busa/busb.
- Produces result q and new flag byte f_out from f_in.
- Outputs are registered; results appear one cycle after the inputs are applied.

---
 rtl/z80_alu.sv | 209 ++++++++++++++++++++
 tb/tb_z80_alu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_alu.sv
// Z80 8-bit ALU with registered result and flag outputs (1-cycle latency).
// Undocumented X/Y flag generation is enabled by defining Z80_ALU_UNDOC_XY_EN.
module z80_alu (
    input  logic       clk,
    input  logic       reset,
    input  logic       arith16,
    input  logic       z16,
    input  logic       alu_cpi,
    input  logic [3:0] alu_op,
    input  logic [5:0] ir,
    input  logic [1:0] iset,
    input  logic [7:0] busa,
    input  logic [7:0] busb,
    input  logic [7:0] f_in,
    output logic [7:0] q,
    output logic [7:0] f_out
);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpAdc = 4'd1;
    localparam logic [3:0] OpSub = 4'd2;
    localparam logic [3:0] OpSbc = 4'd3;
    localparam logic [3:0] OpAnd = 4'd4;
    localparam logic [3:0] OpXor = 4'd5;
    localparam logic [3:0] OpOr  = 4'd6;
    localparam logic [3:0] OpCp  = 4'd7;
    localparam logic [3:0] OpRot = 4'd8;
    localparam logic [3:0] OpBit = 4'd9;
    localparam logic [3:0] OpSet = 4'd10;
    localparam logic [3:0] OpRes = 4'd11;
    localparam logic [3:0] OpDaa = 4'd12;
    localparam logic [3:0] OpRld = 4'd13;
    localparam logic [3:0] OpRrd = 4'd14;

    localparam int unsigned FlagS  = 7;
    localparam int unsigned FlagZ  = 6;
    localparam int unsigned FlagY  = 5;
    localparam int unsigned FlagH  = 4;
    localparam int unsigned FlagX  = 3;
    localparam int unsigned FlagPV = 2;
    localparam int unsigned FlagN  = 1;
    localparam int unsigned FlagC  = 0;

    logic       sub;
    logic       c0;
    logic [8:0] add_sum;
    logic [4:0] add_half;
    logic       add_ovf;
    logic [7:0] cpi_t;
    logic [7:0] logic_res;
    logic [7:0] rot_res;
    logic       rot_c;
    logic [2:0] bit_n;
    logic [7:0] bit_mask;
    logic       daa_lo;
    logic       daa_hi;
    logic [7:0] daa_corr;
    logic [7:0] daa_res;
    logic [7:0] res_d;
    logic [7:0] flag_raw;
    logic [7:0] flag_d;
    logic       unused_ir_lo;

    assign unused_ir_lo = ^ir[2:0];

    // Shared adder for ADD/ADC/SUB/SBC/CP; bit 8 is carry or borrow.
    assign sub = alu_op[1];
    assign c0  = ((alu_op == OpAdc) || (alu_op == OpSbc)) ? f_in[FlagC] : 1'b0;

    assign add_sum  = sub ? ({1'b0, busa} - {1'b0, busb} - {8'b0, c0})
                          : ({1'b0, busa} + {1'b0, busb} + {8'b0, c0});
    assign add_half = sub ? ({1'b0, busa[3:0]} - {1'b0, busb[3:0]} - {4'b0, c0})
                          : ({1'b0, busa[3:0]} + {1'b0, busb[3:0]} + {4'b0, c0});
    assign add_ovf  = sub ? ((busa[7] ^ busb[7]) & (add_sum[7] ^ busa[7]))
                          : (~(busa[7] ^ busb[7]) & (add_sum[7] ^ busa[7]));
    assign cpi_t    = add_sum[7:0] - {7'b0, add_half[4]};

    assign logic_res = (alu_op == OpAnd) ? (busa & busb) :
                       (alu_op == OpXor) ? (busa ^ busb) : (busa | busb);

    assign bit_n    = ir[5:3];
    assign bit_mask = 8'd1 << bit_n;

    assign daa_lo   = (busa[3:0] > 4'd9) | f_in[FlagH];
    assign daa_hi   = busa > 8'h99;
    assign daa_corr = {1'b0, daa_hi | f_in[FlagC], daa_hi | f_in[FlagC], 2'b00,
                       daa_lo, daa_lo, 1'b0};
    assign daa_res  = f_in[FlagN] ? (busa - daa_corr) : (busa + daa_corr);

    always_comb begin
        rot_res = busa;
        rot_c   = 1'b0;
        case (ir[5:3])
            3'd0: begin rot_res = {busa[6:0], busa[7]};     rot_c = busa[7]; end
            3'd1: begin rot_res = {busa[0], busa[7:1]};     rot_c = busa[0]; end
            3'd2: begin rot_res = {busa[6:0], f_in[FlagC]}; rot_c = busa[7]; end
            3'd3: begin rot_res = {f_in[FlagC], busa[7:1]}; rot_c = busa[0]; end
            3'd4: begin rot_res = {busa[6:0], 1'b0};        rot_c = busa[7]; end
            3'd5: begin rot_res = {busa[7], busa[7:1]};     rot_c = busa[0]; end
            3'd6: begin rot_res = {busa[6:0], 1'b1};        rot_c = busa[7]; end
            3'd7: begin rot_res = {1'b0, busa[7:1]};        rot_c = busa[0]; end
        endcase
    end

    always_comb begin
        res_d    = 8'h00;
        flag_raw = f_in;
        case (alu_op)
            OpAdd, OpAdc, OpSub, OpSbc, OpCp: begin
                res_d            = add_sum[7:0];
                flag_raw[FlagC]  = add_sum[8];
                flag_raw[FlagH]  = add_half[4];
                flag_raw[FlagN]  = sub;
                if (!arith16) begin
                    flag_raw[FlagS]  = add_sum[7];
                    flag_raw[FlagZ]  = (add_sum[7:0] == 8'h00) & (~z16 | f_in[FlagZ]);
                    flag_raw[FlagPV] = add_ovf;
                end
                if (alu_op != OpCp) begin
                    flag_raw[FlagY] = add_sum[5];
                    flag_raw[FlagX] = add_sum[3];
                end else if (alu_cpi) begin
                    flag_raw[FlagY] = cpi_t[1];
                    flag_raw[FlagX] = cpi_t[3];
                end else begin
                    flag_raw[FlagY] = busb[5];
                    flag_raw[FlagX] = busb[3];
                end
            end
            OpAnd, OpXor, OpOr: begin
                res_d            = logic_res;
                flag_raw[FlagC]  = 1'b0;
                flag_raw[FlagN]  = 1'b0;
                flag_raw[FlagH]  = (alu_op == OpAnd);
                flag_raw[FlagS]  = res_d[7];
                flag_raw[FlagZ]  = (res_d == 8'h00);
                flag_raw[FlagY]  = res_d[5];
                flag_raw[FlagX]  = res_d[3];
                flag_raw[FlagPV] = ~^res_d;
            end
            OpRot: begin
                res_d           = rot_res;
                flag_raw[FlagC] = rot_c;
                flag_raw[FlagH] = 1'b0;
                flag_raw[FlagN] = 1'b0;
                flag_raw[FlagY] = res_d[5];
                flag_raw[FlagX] = res_d[3];
                // Unprefixed accumulator rotates leave S/Z/PV alone.
                if (iset != 2'b00) begin
                    flag_raw[FlagS]  = res_d[7];
                    flag_raw[FlagZ]  = (res_d == 8'h00);
                    flag_raw[FlagPV] = ~^res_d;
                end
            end
            OpBit: begin
                res_d            = busb & bit_mask;
                flag_raw[FlagZ]  = ~busb[bit_n];
                flag_raw[FlagPV] = ~busb[bit_n];
                flag_raw[FlagH]  = 1'b1;
                flag_raw[FlagN]  = 1'b0;
                flag_raw[FlagS]  = (bit_n == 3'd7) & busb[7];
                flag_raw[FlagY]  = busb[5];
                flag_raw[FlagX]  = busb[3];
            end
            OpSet: res_d = busb | bit_mask;
            OpRes: res_d = busb & ~bit_mask;
            OpDaa: begin
                res_d            = daa_res;
                flag_raw[FlagC]  = f_in[FlagC] | daa_hi;
                flag_raw[FlagH]  = f_in[FlagN] ? (f_in[FlagH] & (busa[3:0] < 4'd6))
                                               : (busa[3:0] > 4'd9);
                flag_raw[FlagS]  = res_d[7];
                flag_raw[FlagZ]  = (res_d == 8'h00);
                flag_raw[FlagY]  = res_d[5];
                flag_raw[FlagX]  = res_d[3];
                flag_raw[FlagPV] = ~^res_d;
            end
            OpRld, OpRrd: begin
                res_d            = (alu_op == OpRld) ? {busa[7:4], busb[7:4]}
                                                     : {busa[7:4], busb[3:0]};
                flag_raw[FlagH]  = 1'b0;
                flag_raw[FlagN]  = 1'b0;
                flag_raw[FlagS]  = res_d[7];
                flag_raw[FlagZ]  = (res_d == 8'h00);
                flag_raw[FlagY]  = res_d[5];
                flag_raw[FlagX]  = res_d[3];
                flag_raw[FlagPV] = ~^res_d;
            end
            default: ;
        endcase
    end

`ifdef Z80_ALU_UNDOC_XY_EN
    assign flag_d = flag_raw;
`else
    assign flag_d = {flag_raw[7:6], f_in[FlagY], flag_raw[4], f_in[FlagX], flag_raw[2:0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= 8'h00;
            f_out <= 8'h00;
        end else begin
            q     <= res_d;
            f_out <= flag_d;
        end
    end

endmodule

// File: tb/tb_z80_alu.sv
// Self-checking bench for z80_alu: directed cases plus random vectors against an
// integer-arithmetic reference model (honours Z80_ALU_UNDOC_XY_EN like the design).
module tb_z80_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic       arith16;
    logic       z16;
    logic       alu_cpi;
    logic [3:0] alu_op;
    logic [5:0] ir;
    logic [1:0] iset;
    logic [7:0] busa;
    logic [7:0] busb;
    logic [7:0] f_in;
    logic [7:0] q;
    logic [7:0] f_out;

    int vectors     = 0;
    int miscompares = 0;

    z80_alu dut (
        .clk     (clk),
        .reset   (reset),
        .arith16 (arith16),
        .z16     (z16),
        .alu_cpi (alu_cpi),
        .alu_op  (alu_op),
        .ir      (ir),
        .iset    (iset),
        .busa    (busa),
        .busb    (busb),
        .f_in    (f_in),
        .q       (q),
        .f_out   (f_out)
    );

    always #5 clk = ~clk;

    function automatic int even_par(input int v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += (v >> i) & 1;
        return (c % 2 == 0) ? 1 : 0;
    endfunction

    // S, Z, Y, X and even parity taken from an 8-bit result.
    function automatic logic [7:0] szxyp(input logic [7:0] fv, input int v);
        logic [7:0] f;
        f    = fv;
        f[7] = (v > 127);
        f[6] = (v == 0);
        f[5] = v[5];
        f[3] = v[3];
        f[2] = even_par(v) != 0;
        return f;
    endfunction

    function automatic logic [15:0] model(input logic [3:0] op, input logic [5:0] irv,
                                          input logic [1:0] is, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] fi,
                                          input logic a16, input logic zz, input logic cpi);
        int ai, bi, ci, c0, r, h, sa, sb, sr, res, t, hh, n, corr, lo, bitv;
        logic [7:0] f;
        ai = a; bi = b; ci = fi[0] ? 1 : 0; f = fi; res = 0;
        n = int'(irv[5:3]);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd7: begin
                c0 = (op == 4'd1 || op == 4'd3) ? ci : 0;
                sa = (ai > 127) ? ai - 256 : ai;
                sb = (bi > 127) ? bi - 256 : bi;
                if (op[1]) begin
                    r = ai - bi - c0; h = (ai % 16) - (bi % 16) - c0; sr = sa - sb - c0;
                end else begin
                    r = ai + bi + c0; h = (ai % 16) + (bi % 16) + c0; sr = sa + sb + c0;
                end
                res  = r & 255;
                f[0] = (r < 0) || (r > 255);
                f[4] = (h < 0) || (h > 15);
                f[1] = op[1];
                if (!a16) begin
                    f[7] = res > 127;
                    f[6] = (res == 0) && (!zz || fi[6]);
                    f[2] = (sr < -128) || (sr > 127);
                end
                if (op == 4'd7 && cpi) begin
                    hh = f[4] ? 1 : 0;
                    t = (res - hh) & 255;
                    f[5] = t[1]; f[3] = t[3];
                end else if (op == 4'd7) begin
                    f[5] = b[5]; f[3] = b[3];
                end else begin
                    f[5] = res[5]; f[3] = res[3];
                end
            end
            4'd4, 4'd5, 4'd6: begin
                res = (op == 4'd4) ? (ai & bi) : (op == 4'd5) ? (ai ^ bi) : (ai | bi);
                f[0] = 1'b0; f[1] = 1'b0; f[4] = (op == 4'd4);
                f = szxyp(f, res);
            end
            4'd8: begin
                case (n)
                    0: begin res = (ai * 2 + ai / 128) % 256; f[0] = ai >= 128; end
                    1: begin res = ai / 2 + (ai % 2) * 128;   f[0] = ai % 2 == 1; end
                    2: begin res = (ai * 2 + ci) % 256;       f[0] = ai >= 128; end
                    3: begin res = ai / 2 + ci * 128;         f[0] = ai % 2 == 1; end
                    4: begin res = (ai * 2) % 256;            f[0] = ai >= 128; end
                    5: begin res = ai / 2 + (ai / 128) * 128; f[0] = ai % 2 == 1; end
                    6: begin res = (ai * 2 + 1) % 256;        f[0] = ai >= 128; end
                    default: begin res = ai / 2;              f[0] = ai % 2 == 1; end
                endcase
                f[4] = 1'b0; f[1] = 1'b0; f[5] = res[5]; f[3] = res[3];
                if (is != 2'b00) f = szxyp(f, res);
            end
            4'd9: begin
                bitv = (bi >> n) & 1;
                res  = bi & (1 << n);
                f[6] = bitv == 0; f[2] = bitv == 0; f[4] = 1'b1; f[1] = 1'b0;
                f[7] = (n == 7) && (bitv == 1); f[5] = b[5]; f[3] = b[3];
            end
            4'd10: res = bi | (1 << n);
            4'd11: res = bi & ~(1 << n) & 255;
            4'd12: begin
                lo = ai % 16; corr = 0;
                if (lo > 9 || fi[4]) corr += 6;
                if (ai > 153 || fi[0]) corr += 96;
                res  = fi[1] ? ((ai - corr) & 255) : ((ai + corr) & 255);
                f[0] = fi[0] || (ai > 153);
                f[4] = fi[1] ? (fi[4] && lo < 6) : (lo > 9);
                f = szxyp(f, res);
            end
            4'd13, 4'd14: begin
                res  = (ai / 16) * 16 + ((op == 4'd13) ? bi / 16 : bi % 16);
                f[4] = 1'b0; f[1] = 1'b0;
                f = szxyp(f, res);
            end
            default: res = 0;
        endcase
`ifndef Z80_ALU_UNDOC_XY_EN
        f[5] = fi[5];
        f[3] = fi[3];
`endif
        return {res[7:0], f};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [5:0] irv, input logic [1:0] is,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] fi,
                         input logic a16, input logic zz, input logic cpi);
        @(negedge clk);
        alu_op = op; ir = irv; iset = is; busa = a; busb = b; f_in = fi;
        arith16 = a16; z16 = zz; alu_cpi = cpi;
    endtask

    task automatic check(input string tag, input logic [7:0] eq, input logic [7:0] ef);
        vectors++;
        assert ({q, f_out} === {eq, ef}) else begin
            miscompares++;
            $error("FAIL %s: q/f=%h/%h expected %h/%h", tag, q, f_out, eq, ef);
        end
    endtask

    // Apply one vector, wait for the capturing edge, compare against the model.
    task automatic step(input string tag, input logic [3:0] op, input logic [5:0] irv,
                        input logic [1:0] is, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] fi, input logic a16, input logic zz,
                        input logic cpi);
        logic [15:0] e;
        drive(op, irv, is, a, b, fi, a16, zz, cpi);
        e = model(op, irv, is, a, b, fi, a16, zz, cpi);
        @(posedge clk);
        #1;
        check(tag, e[15:8], e[7:0]);
    endtask

    task automatic step_const(input string tag, input logic [3:0] op, input logic [5:0] irv,
                              input logic [1:0] is, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] fi, input logic [7:0] eq,
                              input logic [7:0] ef);
        drive(op, irv, is, a, b, fi, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check(tag, eq, ef);
    endtask

    initial begin
        logic [3:0] rop;
        logic       ra16;
        reset = 1'b1;
        drive(4'd0, 6'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Values whose X/Y bits are the same with or without the undocumented flags.
        step_const("add_7f_01", 4'd0, 6'd0, 2'b00, 8'h7F, 8'h01, 8'h00, 8'h80, 8'h94);
        step_const("rlc_iset0", 4'd8, 6'd0, 2'b00, 8'h81, 8'h00, 8'hC4, 8'h03, 8'hC5);
        step_const("rlc_iset1", 4'd8, 6'd0, 2'b01, 8'h81, 8'h00, 8'hC4, 8'h03, 8'h05);
        step_const("bit7",      4'd9, 6'o70, 2'b01, 8'h00, 8'h80, 8'h01, 8'h80, 8'h91);
        step_const("daa_9a",    4'd12, 6'd0, 2'b00, 8'h9A, 8'h00, 8'h00, 8'h00, 8'h55);
        step_const("op15",      4'd15, 6'd0, 2'b00, 8'h12, 8'h34, 8'hA7, 8'h00, 8'hA7);

        step("sbc_00_00",  4'd3, 6'd0, 2'b00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        step("cp_10_28",   4'd7, 6'd0, 2'b00, 8'h10, 8'h28, 8'h00, 1'b0, 1'b0, 1'b0);
        step("cpi_10_28",  4'd7, 6'd0, 2'b10, 8'h10, 8'h28, 8'h00, 1'b0, 1'b0, 1'b1);
        step("add_carry",  4'd0, 6'd0, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        step("sub_ovf",    4'd2, 6'd0, 2'b00, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        step("adc_z16_0",  4'd1, 6'd0, 2'b00, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
        step("adc_z16_1",  4'd1, 6'd0, 2'b00, 8'hFF, 8'h00, 8'h41, 1'b0, 1'b1, 1'b0);
        step("add_ar16",   4'd0, 6'd0, 2'b00, 8'h80, 8'h80, 8'h44, 1'b1, 1'b0, 1'b0);
        step("sra_81",     4'd8, 6'o50, 2'b01, 8'h81, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step("sll_80",     4'd8, 6'o60, 2'b01, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step("rr_cin",     4'd8, 6'o30, 2'b00, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        step("daa_sub",    4'd12, 6'd0, 2'b00, 8'h0F, 8'h00, 8'h12, 1'b0, 1'b0, 1'b0);
        step("bit0_zero",  4'd9, 6'o00, 2'b01, 8'h00, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
        step("set3",       4'd10, 6'o30, 2'b01, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
        step("res7",       4'd11, 6'o70, 2'b01, 8'h00, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b0);
        step("rld",        4'd13, 6'd0, 2'b10, 8'hA5, 8'h3C, 8'h01, 1'b0, 1'b0, 1'b0);
        step("rrd",        4'd14, 6'd0, 2'b10, 8'hA5, 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0);
        step("and_h",      4'd4, 6'd0, 2'b00, 8'hF0, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);

        // Reset wins over an ADD applied in the same cycle.
        drive(4'd0, 6'd0, 2'b00, 8'h7F, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_add", 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            rop  = 4'($urandom_range(0, 15));
            ra16 = ($urandom_range(0, 3) == 0);
            step("random", rop, 6'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), ra16, !ra16 && ($urandom_range(0, 3) == 0),
                 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
